// File: rtl/res_ttl_pkg.sv
// Shared definitions for the TTL result verdict stage.
// Holds the reference edge count, the tolerance around it, the debounce
// window lengths, the default channel count and the per-channel state type.
package res_ttl_pkg;

  localparam int RES_TTL_N_CH        = 8;
  localparam int RES_TTL_CNT_W       = 8;
  localparam int ETALON_ISPR_RES_TTL = 50;
  localparam int TOL_RES_TTL         = 3;
  localparam int GOOD_WIN_RES_TTL    = 4;
  localparam int BAD_WIN_RES_TTL     = 2;
  localparam int FAIL_CNT_W          = 16;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    ACTIVE  = 2'd1,
    LOST    = 2'd2
  } res_ttl_state_t;

  // Failure counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [FAIL_CNT_W-1:0] sat_inc_fail(input logic [FAIL_CNT_W-1:0] v);
    return (v == {FAIL_CNT_W{1'b1}}) ? v : v + FAIL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/res_ttl_verdict_if.sv
// Serial window-count stream from the TTL edge counter.
// Ports (signals):
//   cnt_valid : one-cycle strobe, cnt_chan/cnt_value valid
//   cnt_chan  : channel index of the completed window
//   cnt_value : falling-edge count of that window
// master drives the stream, slave (the verdict stage) consumes it.
interface res_ttl_verdict_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
);
  logic                    cnt_valid;
  logic [$clog2(N_CH)-1:0] cnt_chan;
  logic [CNT_W-1:0]        cnt_value;

  modport master (output cnt_valid, output cnt_chan, output cnt_value);
  modport slave  (input  cnt_valid, input  cnt_chan, input  cnt_value);
endinterface

// File: rtl/res_ttl_chan_fsm.sv
// Per-channel debounce state machine.
// Ports:
//   clk_100Mz, rst : clock, synchronous active-high reset
//   upd            : this channel's window result is present this cycle
//   good           : the presented count lies inside the tolerance window
//   clr            : clear sticky fault and failure counter
//   active         : registered, channel is in ACTIVE
//   fault          : registered sticky fault (left ACTIVE since last clear)
//   fail_cnt_next  : failure counter value including this cycle's update
//   rise / fall    : combinational transition strobes into / out of ACTIVE,
//                    registered by the parent as events
module res_ttl_chan_fsm
  import res_ttl_pkg::*;
#(
  parameter int GOOD_WIN = GOOD_WIN_RES_TTL,
  parameter int BAD_WIN  = BAD_WIN_RES_TTL
) (
  input  logic                  clk_100Mz,
  input  logic                  rst,
  input  logic                  upd,
  input  logic                  good,
  input  logic                  clr,
  output logic                  active,
  output logic                  fault,
  output logic [FAIL_CNT_W-1:0] fail_cnt_next,
  output logic                  rise,
  output logic                  fall
);

  localparam int GW = $clog2(GOOD_WIN + 1);
  localparam int BW = $clog2(BAD_WIN + 1);

  res_ttl_state_t        state_reg, state_next;
  logic [GW-1:0]         good_reg, good_next;
  logic [BW-1:0]         bad_reg, bad_next;
  logic [FAIL_CNT_W-1:0] fail_reg;
  logic                  fault_reg, fault_next;

  // Transitions are judged on the streak values after this sample.
  always_comb begin
    good_next     = good_reg;
    bad_next      = bad_reg;
    fail_cnt_next = clr ? '0 : fail_reg;
    state_next    = state_reg;
    rise          = 1'b0;
    fall          = 1'b0;
    if (upd) begin
      if (good) begin
        good_next = (good_reg == GW'(GOOD_WIN)) ? good_reg : good_reg + GW'(1);
        bad_next  = '0;
      end else begin
        bad_next      = (bad_reg == BW'(BAD_WIN)) ? bad_reg : bad_reg + BW'(1);
        good_next     = '0;
        // An increment in the same cycle as a clear restarts from one.
        fail_cnt_next = clr ? FAIL_CNT_W'(1) : sat_inc_fail(fail_reg);
      end
      case (state_reg)
        UNKNOWN: begin
          if (good_next == GW'(GOOD_WIN)) begin
            state_next = ACTIVE;
            rise       = 1'b1;
          end else if (bad_next == BW'(BAD_WIN)) begin
            state_next = LOST;
          end
        end
        ACTIVE: begin
          if (bad_next == BW'(BAD_WIN)) begin
            state_next = LOST;
            fall       = 1'b1;
          end
        end
        LOST: begin
          if (good_next == GW'(GOOD_WIN)) begin
            state_next = ACTIVE;
            rise       = 1'b1;
          end
        end
        default: state_next = UNKNOWN;
      endcase
    end
    // Setting the fault wins over a simultaneous clear.
    fault_next = fall ? 1'b1 : (clr ? 1'b0 : fault_reg);
  end

  always_ff @(posedge clk_100Mz) begin
    if (rst) begin
      state_reg <= UNKNOWN;
      good_reg  <= '0;
      bad_reg   <= '0;
      fail_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
      bad_reg   <= bad_next;
      fail_reg  <= fail_cnt_next;
      fault_reg <= fault_next;
    end
  end

  assign active = (state_reg == ACTIVE);
  assign fault  = fault_reg;

endmodule

// File: rtl/res_ttl_verdict.sv
// TTL result verdict stage: classifies serial per-channel window counts
// against the reference, debounces them per channel and reports status.
// Ports:
//   clk_100Mz, rst          : clock, synchronous active-high reset
//   cnt_bus (slave)         : serial window-count stream
//   clr_fault               : clear all sticky faults and failure counters
//   rd_chan                 : failure-counter readout select
//   active_channel_res_ttl  : debounced per-channel "alive" vector
//   fault_channel           : sticky per-channel fault vector
//   rd_fail_cnt             : failure count of rd_chan (1-cycle latency)
//   evt_valid/evt_chan/evt_up : one-cycle change event into/out of ACTIVE
module res_ttl_verdict
  import res_ttl_pkg::*;
#(
  parameter int N_CH     = RES_TTL_N_CH,
  parameter int CNT_W    = RES_TTL_CNT_W,
  parameter int ETALON   = ETALON_ISPR_RES_TTL,
  parameter int TOL      = TOL_RES_TTL,
  parameter int GOOD_WIN = GOOD_WIN_RES_TTL,
  parameter int BAD_WIN  = BAD_WIN_RES_TTL,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic                  clk_100Mz,
  input  logic                  rst,
  res_ttl_verdict_if.slave      cnt_bus,
  input  logic                  clr_fault,
  input  logic [CH_W-1:0]       rd_chan,
  output logic [N_CH-1:0]       active_channel_res_ttl,
  output logic [N_CH-1:0]       fault_channel,
  output logic [FAIL_CNT_W-1:0] rd_fail_cnt,
  output logic                  evt_valid,
  output logic [CH_W-1:0]       evt_chan,
  output logic                  evt_up
);

  // One extra bit so ETALON+TOL never wraps at the count width.
  localparam int            CW1      = CNT_W + 1;
  localparam logic [CW1-1:0] LO_BOUND = CW1'(ETALON - TOL);
  localparam logic [CW1-1:0] HI_BOUND = CW1'(ETALON + TOL);

  logic [CW1-1:0]        cnt_ext;
  logic                  cnt_good;
  logic [N_CH-1:0]       upd;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       fall;
  logic [FAIL_CNT_W-1:0] fail_next [N_CH];

  logic                  evt_valid_next;
  logic [CH_W-1:0]       evt_chan_next;
  logic                  evt_up_next;
  logic [FAIL_CNT_W-1:0] rd_fail_next;

  assign cnt_ext  = {1'b0, cnt_bus.cnt_value};
  assign cnt_good = (cnt_ext > LO_BOUND) && (cnt_ext < HI_BOUND);

  // Index decode: a channel number with no matching instance updates nobody.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign upd[gi] = cnt_bus.cnt_valid && (cnt_bus.cnt_chan == CH_W'(gi));

    res_ttl_chan_fsm #(
      .GOOD_WIN (GOOD_WIN),
      .BAD_WIN  (BAD_WIN)
    ) u_chan_fsm (
      .clk_100Mz     (clk_100Mz),
      .rst           (rst),
      .upd           (upd[gi]),
      .good          (cnt_good),
      .clr           (clr_fault),
      .active        (active_channel_res_ttl[gi]),
      .fault         (fault_channel[gi]),
      .fail_cnt_next (fail_next[gi]),
      .rise          (rise[gi]),
      .fall          (fall[gi])
    );
  end

  // Only one channel updates per cycle, so at most one strobe is set.
  always_comb begin
    evt_valid_next = 1'b0;
    evt_chan_next  = '0;
    evt_up_next    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rise[i] || fall[i]) begin
        evt_valid_next = 1'b1;
        evt_chan_next  = CH_W'(i);
        evt_up_next    = rise[i];
      end
    end
  end

  // Readout uses the post-update counter so a same-cycle sample is included.
  always_comb begin
    rd_fail_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_chan == CH_W'(i)) begin
        rd_fail_next = fail_next[i];
      end
    end
  end

  always_ff @(posedge clk_100Mz) begin
    if (rst) begin
      evt_valid   <= 1'b0;
      evt_chan    <= '0;
      evt_up      <= 1'b0;
      rd_fail_cnt <= '0;
    end else begin
      evt_valid   <= evt_valid_next;
      evt_chan    <= evt_chan_next;
      evt_up      <= evt_up_next;
      rd_fail_cnt <= rd_fail_next;
    end
  end

endmodule

// File: tb/tb_res_ttl_verdict.sv
// Directed bench for res_ttl_verdict: a vector table walked in a loop plus
// hand-written sequences for the reset corner case.
module tb_res_ttl_verdict;
  import res_ttl_pkg::*;

  logic        clk_100Mz = 1'b0;
  logic        rst;
  logic        clr_fault;
  logic [2:0]  rd_chan;
  logic [7:0]  active_channel_res_ttl;
  logic [7:0]  fault_channel;
  logic [15:0] rd_fail_cnt;
  logic        evt_valid;
  logic [2:0]  evt_chan;
  logic        evt_up;

  always #5 clk_100Mz = ~clk_100Mz;

  res_ttl_verdict_if #(.N_CH(8), .CNT_W(8)) cnt_bus ();

  res_ttl_verdict dut (
    .clk_100Mz              (clk_100Mz),
    .rst                    (rst),
    .cnt_bus                (cnt_bus),
    .clr_fault              (clr_fault),
    .rd_chan                (rd_chan),
    .active_channel_res_ttl (active_channel_res_ttl),
    .fault_channel          (fault_channel),
    .rd_fail_cnt            (rd_fail_cnt),
    .evt_valid              (evt_valid),
    .evt_chan               (evt_chan),
    .evt_up                 (evt_up)
  );

  typedef struct {
    bit         vld;
    int         ch;
    int         val;
    bit         clr;
    int         rd;
    logic [7:0] act;
    logic [7:0] flt;
    bit         ev;
    int         evc;
    bit         evu;
    int         rdv;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Returns 1 ns after the edge, where outputs are stable and inputs may change.
  task automatic step();
    @(posedge clk_100Mz);
    #1;
  endtask

  task automatic apply(input bit vld, input int ch, input int val, input bit clr, input int rd);
    cnt_bus.cnt_valid = vld;
    cnt_bus.cnt_chan  = 3'(ch);
    cnt_bus.cnt_value = 8'(val);
    clr_fault         = clr;
    rd_chan           = 3'(rd);
    step();
    cnt_bus.cnt_valid = 1'b0;
    clr_fault         = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] act, input logic [7:0] flt,
                            input bit ev, input int evc, input bit evu, input int rdv);
    chk({tag, " active"}, 32'(active_channel_res_ttl), 32'(act));
    chk({tag, " fault"}, 32'(fault_channel), 32'(flt));
    chk({tag, " evt_valid"}, 32'(evt_valid), 32'(ev));
    if (ev) begin
      chk({tag, " evt_chan"}, 32'(evt_chan), 32'(evc));
      chk({tag, " evt_up"}, 32'(evt_up), 32'(evu));
    end
    chk({tag, " rd_fail_cnt"}, 32'(rd_fail_cnt), 32'(rdv));
  endtask

  task automatic add(input bit vld, input int ch, input int val, input bit clr, input int rd,
                     input logic [7:0] act, input logic [7:0] flt, input bit ev,
                     input int evc, input bit evu, input int rdv);
    vec_t v;
    v.vld = vld; v.ch = ch; v.val = val; v.clr = clr; v.rd = rd;
    v.act = act; v.flt = flt; v.ev = ev; v.evc = evc; v.evu = evu; v.rdv = rdv;
    vecs.push_back(v);
  endtask

  initial begin
    rst               = 1'b1;
    clr_fault         = 1'b0;
    rd_chan           = '0;
    cnt_bus.cnt_valid = 1'b0;
    cnt_bus.cnt_chan  = '0;
    cnt_bus.cnt_value = '0;

    // ch0: four good windows -> active with up event
    for (int i = 0; i < 3; i++) add(1, 0, 50, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 50, 0, 0, 8'h01, 8'h00, 1, 0, 1, 0);
    // ch1: 47, 53 bad from UNKNOWN -> LOST silently; 48/52 good -> back up
    add(1, 1, 47, 0, 1, 8'h01, 8'h00, 0, 0, 0, 1);
    add(1, 1, 53, 0, 1, 8'h01, 8'h00, 0, 0, 0, 2);
    add(1, 1, 48, 0, 1, 8'h01, 8'h00, 0, 0, 0, 2);
    add(1, 1, 52, 0, 1, 8'h01, 8'h00, 0, 0, 0, 2);
    add(1, 1, 48, 0, 1, 8'h01, 8'h00, 0, 0, 0, 2);
    add(1, 1, 52, 0, 1, 8'h03, 8'h00, 1, 1, 1, 2);
    // ch2: activate, then 51, 45, 60 -> drop with fault
    for (int i = 0; i < 3; i++) add(1, 2, 50, 0, 2, 8'h03, 8'h00, 0, 0, 0, 0);
    add(1, 2, 50, 0, 2, 8'h07, 8'h00, 1, 2, 1, 0);
    add(1, 2, 51, 0, 2, 8'h07, 8'h00, 0, 0, 0, 0);
    add(1, 2, 45, 0, 2, 8'h07, 8'h00, 0, 0, 0, 1);
    add(1, 2, 60, 0, 2, 8'h03, 8'h04, 1, 2, 0, 2);
    for (int i = 0; i < 3; i++) add(1, 2, 50, 0, 2, 8'h03, 8'h04, 0, 0, 0, 2);
    add(1, 2, 50, 0, 2, 8'h07, 8'h04, 1, 2, 1, 2);
    add(0, 0, 0, 0, 1, 8'h07, 8'h04, 0, 0, 0, 2);
    // ch3 good / ch4 bad interleaved back-to-back
    add(1, 3, 50, 0, 4, 8'h07, 8'h04, 0, 0, 0, 0);
    add(1, 4, 10, 0, 4, 8'h07, 8'h04, 0, 0, 0, 1);
    add(1, 3, 50, 0, 4, 8'h07, 8'h04, 0, 0, 0, 1);
    add(1, 4, 10, 0, 4, 8'h07, 8'h04, 0, 0, 0, 2);
    add(1, 3, 50, 0, 4, 8'h07, 8'h04, 0, 0, 0, 2);
    add(1, 4, 10, 0, 4, 8'h07, 8'h04, 0, 0, 0, 3);
    add(1, 3, 50, 0, 4, 8'h0F, 8'h04, 1, 3, 1, 3);
    add(1, 4, 255, 0, 4, 8'h0F, 8'h04, 0, 0, 0, 4);
    // ch2 active: second bad window coincides with clr_fault
    add(1, 2, 40, 0, 2, 8'h0F, 8'h04, 0, 0, 0, 3);
    add(1, 2, 40, 1, 2, 8'h0B, 8'h04, 1, 2, 0, 1);
    add(0, 0, 0, 1, 2, 8'h0B, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 8'h0B, 8'h00, 0, 0, 0, 0);

    step();
    step();
    check_outs("reset", 8'h00, 8'h00, 0, 0, 0, 0);
    chk("reset evt_chan", 32'(evt_chan), 32'd0);
    chk("reset evt_up", 32'(evt_up), 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      apply(vecs[k].vld, vecs[k].ch, vecs[k].val, vecs[k].clr, vecs[k].rd);
      $display("vec %0d vld=%0d ch=%0d val=%0d clr=%0d rd=%0d -> act=%h flt=%h evt=%0d/%0d/%0d rd_cnt=%0d",
               k, vecs[k].vld, vecs[k].ch, vecs[k].val, vecs[k].clr, vecs[k].rd,
               active_channel_res_ttl, fault_channel, evt_valid, evt_chan, evt_up, rd_fail_cnt);
      check_outs($sformatf("vec%0d", k), vecs[k].act, vecs[k].flt, vecs[k].ev,
                 vecs[k].evc, vecs[k].evu, vecs[k].rdv);
    end

    // ch4 one more bad window so reset has a nonzero counter to clear
    apply(1, 4, 0, 0, 4);
    $display("seq ch4 bad -> rd_cnt=%0d", rd_fail_cnt);
    check_outs("ch4 bad", 8'h0B, 8'h00, 0, 0, 0, 1);

    // ch5 to ACTIVE
    for (int i = 0; i < 4; i++) begin
      apply(1, 5, 50, 0, 5);
      $display("seq ch5 good %0d -> act=%h evt=%0d", i, active_channel_res_ttl, evt_valid);
    end
    check_outs("ch5 up", 8'h2B, 8'h00, 1, 5, 1, 0);

    // reset together with a ch5 sample: sample must be dropped
    rst = 1'b1;
    apply(1, 5, 50, 0, 4);
    rst = 1'b0;
    $display("seq reset -> act=%h flt=%h evt=%0d rd_cnt=%0d",
             active_channel_res_ttl, fault_channel, evt_valid, rd_fail_cnt);
    check_outs("mid reset", 8'h00, 8'h00, 0, 0, 0, 0);
    chk("mid reset evt_chan", 32'(evt_chan), 32'd0);
    chk("mid reset evt_up", 32'(evt_up), 32'd0);

    for (int i = 0; i < 3; i++) begin
      apply(1, 5, 50, 0, 5);
      $display("seq ch5 fresh good %0d -> act=%h evt=%0d", i, active_channel_res_ttl, evt_valid);
      check_outs($sformatf("ch5 fresh%0d", i), 8'h00, 8'h00, 0, 0, 0, 0);
    end
    apply(1, 5, 50, 0, 5);
    $display("seq ch5 fresh good 3 -> act=%h evt=%0d", active_channel_res_ttl, evt_valid);
    check_outs("ch5 reup", 8'h20, 8'h00, 1, 5, 1, 0);

    apply(0, 0, 0, 0, 5);
    check_outs("ch5 evt pulse", 8'h20, 8'h00, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/res_ttl_verdict.md
# res_ttl_verdict

Per-channel verdict stage downstream of the TTL result edge counter. Consumes one falling-edge count per channel per 1 MHz measurement window, delivered serially. Judges each count against the reference value ETALON_ISPR_RES_TTL. Debounces the verdicts over consecutive windows into a stable `active_channel_res_ttl` vector, sticky fault flags, per-channel failure counters and change events for the control/readout logic.

## Interface
- `N_CH`, 8: number of TTL channels.
- `CNT_W`, 8: width of incoming window count.
- `ETALON`, 50: expected falling edges per window (ETALON_ISPR_RES_TTL).
- `TOL`, 3: a count is good iff ETALON−TOL < cnt < ETALON+TOL, i.e. 48..52 at defaults.
- `GOOD_WIN`, 4: consecutive good windows needed to declare a channel active.
- `BAD_WIN`, 2: consecutive bad windows needed to declare a channel lost.
- `clk_100Mz`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `cnt_valid`  in  1  one-cycle strobe: `cnt_chan` and `cnt_value` are valid.
- `cnt_chan`  in  $clog2(N_CH)  channel index of this window result.
- `cnt_value`  in  CNT_W  falling-edge count for that channel's completed window.
- `clr_fault`  in  1  one-cycle pulse: clears all sticky faults and failure counters.
- `rd_chan`  in  $clog2(N_CH)  channel selected for failure-counter readout.
- `active_channel_res_ttl`  out  N_CH  debounced "channel alive" per channel.
- `fault_channel`  out  N_CH  sticky: channel has left ACTIVE since last clear.
- `rd_fail_cnt`  out  16  bad-window count of `rd_chan`, saturating.
- `evt_valid`  out  1  one-cycle pulse on any channel state change into or out of ACTIVE.
- `evt_chan`  out  $clog2(N_CH)  channel of the event.
- `evt_up`  out  1  1 = entered ACTIVE, 0 = left ACTIVE.

## Operation
- Classification: good when the count is inside the strict window. Compare at CNT_W+1 bits so ETALON+TOL cannot overflow.
- Per channel, the block keeps:
  - state ∈ {UNKNOWN, ACTIVE, LOST};
  - good streak and bad streak counters, saturating at GOOD_WIN and BAD_WIN;
  - a 16-bit failure counter;
  - a sticky fault bit.
- Only the channel addressed by `cnt_chan` updates on a `cnt_valid` cycle. All other channels hold.
- Good sample: good streak +1 (saturating), bad streak ← 0.
- Bad sample: bad streak +1 (saturating), good streak ← 0, failure counter +1 (saturating at 0xFFFF).
- State transitions, evaluated on the post-update streak:
  - UNKNOWN → ACTIVE when good streak = GOOD_WIN.
  - UNKNOWN → LOST when bad streak = BAD_WIN. No event, no fault.
  - ACTIVE → LOST when bad streak = BAD_WIN. Sets fault; event with up=0.
  - LOST → ACTIVE when good streak = GOOD_WIN. Event with up=1.
  - UNKNOWN → ACTIVE also emits an event with up=1.
- `active_channel_res_ttl[i]` = (state_i == ACTIVE).
- `clr_fault`:
  - clears all fault bits and failure counters;
  - does not change state or streaks.
- Simultaneous `clr_fault` and an update on channel i:
  - a set or increment from that update wins over the clear;
  - fault_i = 1 if ACTIVE→LOST occurs in that cycle, else 0;
  - fail_cnt_i = 1 if the sample is bad, else 0.
- `cnt_chan` ≥ N_CH (only possible when N_CH is not a power of two): the sample is ignored entirely.
- Reset mid-operation:
  - all channels return to UNKNOWN, streaks 0, faults 0, counters 0;
  - any `cnt_valid` in the reset cycle is dropped.

## Timing
- All outputs are registered.
- Latency 1 cycle: a `cnt_valid` at edge k updates `active_channel_res_ttl`, `fault_channel` and `evt_*` after edge k+1.
- `evt_valid` is high for exactly one cycle per transition. At most one event per cycle, because only one channel updates per cycle.
- `rd_fail_cnt` is registered 1 cycle after `rd_chan`. It reflects the counter value including any update made in the same cycle.
- Back-to-back `cnt_valid` on every cycle, including the same channel twice, is supported at full rate.
- Values after reset:
  - `active_channel_res_ttl` = 0, `fault_channel` = 0;
  - `rd_fail_cnt` = 0;
  - `evt_valid` = 0, `evt_chan` = 0, `evt_up` = 0.

## Structure
- Shared package `res_ttl_pkg`:
  - `ETALON_ISPR_RES_TTL` = 50 and the tolerance constant;
  - the `res_ttl_state_t` enum {UNKNOWN, ACTIVE, LOST};
  - channel count N_CH.
- Sub-module `res_ttl_chan_fsm`:
  - holds the per-channel state, streaks, failure counter and fault bit;
  - inputs: update enable, good flag, clear;
  - outputs: active, fault, fail_cnt, rise/fall pulses.
- The top level instantiates `res_ttl_chan_fsm` N_CH times in a generate loop.
- The top level performs classification, index decode, the readout mux and event encoding.

## Test plan
- Ch0 receives 4 windows of 50: `active[0]` rises 1 cycle after the 4th strobe; `evt_valid` with chan=0, up=1; `fault_channel` = 0.
- Boundaries on ch1: counts 48 and 52 count as good; 47 and 53 count as bad. After bad 47, bad 53: ch1 is LOST, no event, `rd_fail_cnt`(1) = 2.
- Ch2 is ACTIVE, then receives 51, 45, 60: drops after the 60; `evt_up` = 0; `fault_channel[2]` = 1; fail count 2. One further good window does not restore it; 4 good windows do, with an up event.
- `clr_fault` in the same cycle as ch2's 2nd bad window while ACTIVE: `fault_channel[2]` = 1 and fail count = 1. A `clr_fault` alone next cycle clears both to 0.
- Interleaved ch3/ch4 strobes on consecutive cycles (3 good, 4 bad, repeated): channels stay independent; ch3 goes active on its 4th good; ch4 goes LOST without an event.
- Assert `rst` while ch5 is ACTIVE with a `cnt_valid` present: all outputs are 0 on the next cycle; the sample is dropped; ch5 needs 4 fresh good windows to reactivate.
